// File: rtl/dkongjr_cap_charge.sv
// RC capacitor charge/discharge envelope: a tick-rate 8.8 accumulator plus a
// sequential shift-add scaler that applies the envelope to the sound sample.
module dkongjr_cap_charge #(
  parameter int DIV       = 512,
  parameter int CHG_SHIFT = 6,
  parameter int DIS_SHIFT = 6
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_CHARGE_EN,
  input  logic signed [15:0] I_SND_DAT,
  output logic        [7:0]  O_ENV,
  output logic signed [15:0] O_SND_DAT,
  output logic               O_SND_VALID
);
  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [15:0]      FULL     = 16'hFF00;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  logic [CNT_W-1:0]   cnt_p0;
  logic               tick_p0;
  logic [15:0]        acc_p1;
  state_t             state_p1;
  logic [2:0]         bit_p1;
  logic signed [23:0] mcand_p1;
  logic [7:0]         mplier_p1;
  logic signed [23:0] prod_p2;

  // A minimum step of one makes both endpoints reachable exactly.
  function automatic logic [15:0] env_charge(input logic [15:0] acc);
    logic [15:0] gap;
    logic [15:0] step;
    gap  = FULL - acc;
    step = gap >> CHG_SHIFT;
    if (step == 16'd0 && gap != 16'd0) step = 16'd1;
    return acc + step;
  endfunction

  function automatic logic [15:0] env_discharge(input logic [15:0] acc);
    logic [15:0] step;
    step = acc >> DIS_SHIFT;
    if (step == 16'd0 && acc != 16'd0) step = 16'd1;
    return acc - step;
  endfunction

  // Stage p0: sample-rate tick generator
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cnt_p0  <= '0;
      tick_p0 <= 1'b0;
    end else begin
      tick_p0 <= (cnt_p0 == CNT_LAST);
      cnt_p0  <= (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + 1'b1;
    end
  end

  // Stage p1: envelope accumulator, direction sampled only on the tick
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      acc_p1 <= 16'h0000;
    end else if (tick_p0) begin
      acc_p1 <= I_CHARGE_EN ? env_charge(acc_p1) : env_discharge(acc_p1);
    end
  end

  assign O_ENV = acc_p1[15:8];

  // Stage p1/p2: multiply sequencer and output register
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_p1    <= IDLE;
      bit_p1      <= 3'd0;
      O_SND_DAT   <= 16'sd0;
      O_SND_VALID <= 1'b0;
    end else begin
      O_SND_VALID <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (tick_p0) begin
            bit_p1   <= 3'd0;
            state_p1 <= MUL;
          end
        end
        MUL: begin
          bit_p1 <= bit_p1 + 3'd1;
          if (bit_p1 == 3'd7) state_p1 <= DONE;
        end
        DONE: begin
          O_SND_DAT   <= prod_p2[23:8];
          O_SND_VALID <= 1'b1;
          state_p1    <= IDLE;
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  // The multiplier uses the envelope from before this tick's update.
  always_ff @(posedge I_CLK) begin
    if (state_p1 == IDLE && tick_p0) begin
      mcand_p1  <= {{8{I_SND_DAT[15]}}, I_SND_DAT};
      mplier_p1 <= O_ENV;
      prod_p2   <= 24'sd0;
    end else if (state_p1 == MUL && mplier_p1[bit_p1]) begin
      prod_p2 <= prod_p2 + (mcand_p1 <<< bit_p1);
    end
  end

endmodule
